mmr_mismatch_monitor: RTL and testbench



---
 rtl/mmr_monitor_pkg.sv | 11 +
 rtl/mismatch_event_counter.sv | 25 ++
 rtl/mmr_mismatch_monitor.sv | 72 +++++++
 tb/tb_mmr_mismatch_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmr_monitor_pkg.sv
// mmr_monitor_pkg: read FSM states, default sizes and saturating increment for the mismatch monitor
package mmr_monitor_pkg;
  localparam int N_SRC_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 16;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max;
    max = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/mismatch_event_counter.sv
// mismatch_event_counter: rising-edge event counter with saturation, sticky flag and event-wins clear
module mismatch_event_counter
  import mmr_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cur,
  input  logic             prev,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sticky
);
  logic ev;
  assign ev = cur & ~prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      cnt    <= clr ? CNT_W'(ev) : ev ? CNT_W'(sat_inc(32'(cnt), CNT_W)) : cnt;
      sticky <= clr ? ev : sticky | ev;
    end
endmodule

// File: rtl/mmr_mismatch_monitor.sv
// mmr_mismatch_monitor: per-source mismatch event counters, sticky flags, irq and a two-state read port
module mmr_mismatch_monitor
  import mmr_monitor_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_SRC-1:0] mismatch_i,
  input  logic             rd_req_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             rd_clr_i,
  input  logic             clr_all_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_err_o,
  output logic [N_SRC-1:0] sticky_o,
  output logic             irq_o
);
  logic [N_SRC-1:0]            mm_q, mm_qq, clr_vec;
  logic [N_SRC-1:0][CNT_W-1:0] cnt;
  logic [IDX_W-1:0]            idx_q;
  logic                        clr_q, idx_ok;
  rd_state_t                   state;
  assign idx_ok = 32'(rd_idx_i) < N_SRC;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      mm_q  <= '0;
      mm_qq <= '0;
      irq_o <= 1'b0;
    end else begin
      mm_q  <= mismatch_i;
      mm_qq <= mm_q;
      irq_o <= |sticky_o;
    end
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign clr_vec[i] = clr_all_i | (state == RD_RESP && clr_q && idx_q == IDX_W'(i));
    mismatch_event_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .cur   (mm_q[i]),
      .prev  (mm_qq[i]),
      .clr   (clr_vec[i]),
      .cnt   (cnt[i]),
      .sticky(sticky_o[i])
    );
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state     <= RD_IDLE;
      rd_ack_o  <= 1'b0;
      rd_data_o <= '0;
      rd_err_o  <= 1'b0;
      idx_q     <= '0;
      clr_q     <= 1'b0;
    end else if (state == RD_IDLE) begin
      rd_ack_o <= rd_req_i;
      if (rd_req_i) begin
        state     <= RD_RESP;
        idx_q     <= rd_idx_i;
        clr_q     <= rd_clr_i & idx_ok;
        rd_data_o <= idx_ok ? cnt[rd_idx_i] : '0;
        rd_err_o  <= !idx_ok;
      end
    end else begin
      state    <= RD_IDLE;
      rd_ack_o <= 1'b0;
      clr_q    <= 1'b0;
    end
endmodule

// File: tb/tb_mmr_mismatch_monitor.sv
// tb_mmr_mismatch_monitor: scoreboard-driven checks of counting, saturation, clears, errors and read handshake
module tb_mmr_mismatch_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, rd_req, rd_clr, clr_all, rd_ack, rd_err, irq;
  logic [5:0] mm, sticky;
  logic [2:0] rd_idx;
  logic [3:0] rd_data;
  logic [4:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  mmr_mismatch_monitor #(.N_SRC(6), .CNT_W(4)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .mismatch_i(mm),
    .rd_req_i  (rd_req),
    .rd_idx_i  (rd_idx),
    .rd_clr_i  (rd_clr),
    .clr_all_i (clr_all),
    .rd_ack_o  (rd_ack),
    .rd_data_o (rd_data),
    .rd_err_o  (rd_err),
    .sticky_o  (sticky),
    .irq_o     (irq)
  );
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      mm[s] = 1'b1;
      @(negedge clk);
      mm[s] = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic do_read(input int idx, input bit clr, input logic [5:0] ev, input bit ca,
                         output bit ok, output logic [4:0] got);
    rd_idx = 3'(idx);
    rd_clr = clr;
    rd_req = 1'b1;
    mm     = mm | ev;
    @(negedge clk);
    rd_req  = 1'b0;
    rd_clr  = 1'b0;
    mm      = mm & ~ev;
    clr_all = ca;
    for (int n = 0; n < 4 && rd_ack !== 1'b1; n++) @(negedge clk);
    ok  = (rd_ack === 1'b1);
    got = {rd_err, rd_data};
    if (ok) @(negedge clk);
    clr_all = 1'b0;
  endtask
  task automatic test_reset();
    bit ok;
    logic [4:0] got, e;
    rst_n = 1'b0; mm = '0; rd_req = 0; rd_clr = 0; clr_all = 0; rd_idx = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    compared++;
    if ({rd_ack, irq, sticky, rd_err, rd_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: ack=%b irq=%b sticky=%h err=%b data=%h required all 0", rd_ack, irq, sticky, rd_err, rd_data);
    end
    pulse(0, 2);
    idle(2);
    compared++;
    if (irq !== 1'b1) begin mismatched++; $display("FAIL pre_reset_irq: got %b required 1", irq); end
    rd_idx = '0;
    rd_req = 1'b1;
    @(posedge clk);
    #2;
    compared++;
    if (rd_ack !== 1'b1) begin mismatched++; $display("FAIL pre_reset_ack: got %b required 1", rd_ack); end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({rd_ack, irq, sticky} !== 8'h00) begin
      mismatched++;
      $display("FAIL async_reset: ack=%b irq=%b sticky=%h required 0 0 00", rd_ack, irq, sticky);
    end
    @(negedge clk);
    rd_req = 1'b0;
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back({1'b0, 4'd0});
    do_read(0, 0, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL reset_read0: ack=%b got=%h required=%h", ok, got, e); end
  endtask
  task automatic test_edge_counting();
    bit ok;
    logic [4:0] got, e;
    mm[2] = 1'b1;
    @(negedge clk);
    mm[2] = 1'b0;
    @(negedge clk);
    compared++;
    if ({sticky, irq} !== {6'h04, 1'b0}) begin
      mismatched++;
      $display("FAIL first_sticky: sticky=%h irq=%b required 04 0", sticky, irq);
    end
    @(negedge clk);
    compared++;
    if (irq !== 1'b1) begin mismatched++; $display("FAIL irq_delay: got %b required 1", irq); end
    pulse(2, 2);
    mm[2] = 1'b1;
    idle(10);
    mm[2] = 1'b0;
    idle(3);
    compared++;
    if (sticky !== 6'h04) begin mismatched++; $display("FAIL edge_sticky: got %h required 04", sticky); end
    exp_q.push_back({1'b0, 4'd4});
    do_read(2, 1, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL edge_read: ack=%b got=%h required=%h", ok, got, e); end
    compared++;
    if (sticky !== 6'h00) begin mismatched++; $display("FAIL clr_on_read_sticky: got %h required 00", sticky); end
  endtask
  task automatic test_saturation();
    bit ok;
    logic [4:0] got, e;
    pulse(0, 20);
    idle(2);
    exp_q.push_back({1'b0, 4'hF});
    exp_q.push_back({1'b0, 4'h0});
    do_read(0, 1, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL sat_read: ack=%b got=%h required=%h", ok, got, e); end
    do_read(0, 0, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL sat_after_clr: ack=%b got=%h required=%h", ok, got, e); end
  endtask
  task automatic test_clear_collision();
    bit ok;
    logic [4:0] got, e;
    pulse(5, 3);
    idle(2);
    exp_q.push_back({1'b0, 4'd3});
    exp_q.push_back({1'b0, 4'd1});
    do_read(5, 1, 6'h20, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL collide_read: ack=%b got=%h required=%h", ok, got, e); end
    compared++;
    if (sticky[5] !== 1'b1) begin mismatched++; $display("FAIL collide_sticky: got %b required 1", sticky[5]); end
    do_read(5, 1, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL collide_next: ack=%b got=%h required=%h", ok, got, e); end
  endtask
  task automatic test_invalid_index();
    bit ok;
    logic [4:0] got, e;
    pulse(1, 2);
    idle(2);
    exp_q.push_back({1'b1, 4'd0});
    exp_q.push_back({1'b0, 4'd2});
    do_read(7, 1, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL invalid_read: ack=%b got=%h required=%h", ok, got, e); end
    compared++;
    if (sticky !== 6'h02) begin mismatched++; $display("FAIL invalid_sticky: got %h required 02", sticky); end
    do_read(1, 1, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL invalid_nochange: ack=%b got=%h required=%h", ok, got, e); end
  endtask
  task automatic test_global_clear();
    bit ok;
    logic [4:0] got, e;
    pulse(3, 2);
    pulse(4, 1);
    idle(2);
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b0, 4'd0});
    exp_q.push_back({1'b0, 4'd0});
    do_read(3, 0, '0, 1, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL clr_all_read: ack=%b got=%h required=%h", ok, got, e); end
    do_read(3, 0, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL clr_all_after3: ack=%b got=%h required=%h", ok, got, e); end
    do_read(4, 0, '0, 0, ok, got);
    e = exp_q.pop_front();
    compared++;
    if (!ok || got !== e) begin mismatched++; $display("FAIL clr_all_after4: ack=%b got=%h required=%h", ok, got, e); end
    compared++;
    if ({sticky, irq} !== 7'h00) begin mismatched++; $display("FAIL clr_all_flags: sticky=%h irq=%b required 00 0", sticky, irq); end
  endtask
  task automatic test_back_to_back();
    logic [4:0] e;
    int acks;
    acks = 0;
    pulse(4, 1);
    idle(2);
    repeat (3) exp_q.push_back({1'b0, 4'd1});
    rd_idx = 3'd4;
    rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_ack === 1'b1) begin
        acks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
        compared++;
        if ({rd_err, rd_data} !== e) begin
          mismatched++;
          $display("FAIL b2b_data: got=%h required=%h", {rd_err, rd_data}, e);
        end
      end
    end
    rd_req = 1'b0;
    idle(2);
    compared++;
    if (acks != 3 || rd_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_ack_count: got %0d acks (ack now %b) required 3", acks, rd_ack);
    end
  endtask
  initial begin
    test_reset();
    test_edge_counting();
    test_saturation();
    test_clear_collision();
    test_invalid_index();
    test_global_clear();
    test_back_to_back();
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
